ram_operand_sequencer: RTL and testbench
========================================

Name: ram_operand_sequencer

Overview:
- Command-driven sequencer that owns port B of the scalar-multiplication operand RAM (Data-wide words, 2^(Addr+1) locations).
- Per command: reads two operands, launches the field arithmetic unit (multiplier/adder), waits for its done, writes the result back to a destination address.
- Sits between the scalar-multiplication top-level control FSM (command source) and the RAM port B / arithmetic unit.
- Port A of the RAM is left to the external loader and is untouched by this block.

Parameters:
- Data, 256, operand/result word width.
- Addr, 5, RAM address MSB index; address width is Addr+1.
- command_len, 1, width of the arithmetic op-code forwarded to the unit.
- TIMEOUT, 1023, maximum EXEC cycles waited for alu_done before error; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&cmd_ready.
- cmd_op  in  command_len  op-code for arithmetic unit.
- cmd_src1  in  Addr+1  address of operand 1.
- cmd_src2  in  Addr+1  address of operand 2.
- cmd_dst  in  Addr+1  result address.
- b_w  out  1  RAM port B write enable.
- b_adbus  out  Addr+1  RAM port B address.
- b_data_in  out  Data  RAM port B write data.
- b_data_out  in  Data  RAM port B read data, valid exactly one cycle after address.
- alu_start  out  1  one-cycle start pulse.
- alu_op  out  command_len  latched op-code.
- alu_op1, alu_op2  out  Data  latched operands, stable from start until done.
- alu_result  in  Data  result, valid in the alu_done cycle.
- alu_done  in  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at successful completion.
- err  out  1  sticky timeout flag; cleared only by rst or by the next accepted command.

Behaviour:
- Reset: state=IDLE; cmd_ready=1 (combinational from IDLE), b_w=0, b_adbus=0, b_data_in=0, alu_start=0, alu_op=0, alu_op1=alu_op2=0, busy=0, done=0, err=0, timeout counter=0. Reset overrides any state, including mid-EXEC and the WB cycle; no write is issued in the cycle rst is high.
- On acceptance, latch src1, src2, dst and op into internal registers; later changes on cmd_* are ignored.
- States and cycle timing (c0 = acceptance cycle):
  - IDLE -> RD1 on accept.
  - RD1 (c1): b_adbus=src1, b_w=0.
  - RD2 (c2): b_adbus=src2; capture alu_op1 <= b_data_out.
  - CAP2 (c3): capture alu_op2 <= b_data_out.
  - EXEC (c4 onward): alu_start=1 in the first EXEC cycle only. alu_done is sampled from the second EXEC cycle onward; a done coincident with start is ignored. On done, capture result into b_data_in and go to WB. The counter increments each EXEC cycle; if it reaches TIMEOUT with no done, set err=1 and go to IDLE without writeback.
  - WB: b_w=1, b_adbus=dst, b_data_in=result, for exactly 1 cycle.
  - DONE: done=1 for 1 cycle, then IDLE.
- Minimum command latency: acceptance to done pulse = 6 + N cycles, where N is the number of EXEC cycles after start until alu_done.
- src1==src2 is legal: both reads are performed and alu_op1==alu_op2.
- dst equal to src1 or src2 is legal; the read completes before the write.
- b_w is never asserted outside WB.
- The full Addr+1 address range is used, with no wrap logic.
- Spurious alu_done outside EXEC is ignored.

Decomposition:
- Shared package scalar_mul_pkg: state encoding constants (IDLE, RD1, RD2, CAP2, EXEC, WB, DONE), the RAM read-latency constant (1), and the default Data/Addr widths.
- One natural sub-module, seq_timeout_counter: a loadable/clearable counter with a terminal flag, parameterised by TIMEOUT.

Test Plan:
- RAM[3]=0x11, RAM[7]=0x22, cmd src1=3, src2=7, dst=9, op=1; model unit returns op1+op2 after 5 cycles -> alu_op1=0x11, alu_op2=0x22, alu_op=1, single alu_start, RAM[9]=0x33, done 11 cycles after accept, err=0.
- src1=src2=dst=4, RAM[4]=0x5, unit returns op1*op2 -> RAM[4]=0x19, exactly one b_w cycle.
- Unit never asserts done, TIMEOUT=15 -> err=1 after 15 EXEC cycles, no b_w, back to IDLE with cmd_ready=1; the next accepted command clears err.
- cmd_valid held high for two back-to-back commands -> the second is accepted only in the cycle after DONE; cmd_ready=0 throughout; cmd_* changes while busy have no effect.
- rst asserted during EXEC and again during the WB cycle -> all outputs at reset values next cycle, no RAM write, busy=0.
- alu_done pulsed in IDLE and in the same cycle as alu_start -> ignored; the sequencer waits for the later genuine done.

Source files
------------

// File: rtl/scalar_mul_pkg.sv
// Shared definitions for the scalar-multiplication datapath: sequencer state
// encoding, RAM timing and default operand/address widths.
package scalar_mul_pkg;

  localparam int DATA_W_DEFAULT   = 256;
  localparam int ADDR_MSB_DEFAULT = 5;
  localparam int RAM_RD_LATENCY   = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    CAP2 = 3'd3,
    EXEC = 3'd4,
    WB   = 3'd5,
    DONE = 3'd6
  } seq_state_e;

endpackage

// File: rtl/seq_timeout_counter.sv
// Clearable up-counter that flags the last cycle before the TIMEOUT limit
// is reached, so the owner can abort in that same cycle.
module seq_timeout_counter #(
  parameter int TIMEOUT = 1023,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic terminal
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == LAST);

endmodule

// File: rtl/ram_operand_sequencer.sv
// Owns RAM port B: reads two operands, runs the field arithmetic unit and
// writes the result back, one command at a time.
module ram_operand_sequencer
  import scalar_mul_pkg::*;
#(
  parameter int Data        = DATA_W_DEFAULT,
  parameter int Addr        = ADDR_MSB_DEFAULT,
  parameter int command_len = 1,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [command_len-1:0] cmd_op,
  input  logic [Addr:0]          cmd_src1,
  input  logic [Addr:0]          cmd_src2,
  input  logic [Addr:0]          cmd_dst,
  output logic                   b_w,
  output logic [Addr:0]          b_adbus,
  output logic [Data-1:0]        b_data_in,
  input  logic [Data-1:0]        b_data_out,
  output logic                   alu_start,
  output logic [command_len-1:0] alu_op,
  output logic [Data-1:0]        alu_op1,
  output logic [Data-1:0]        alu_op2,
  input  logic [Data-1:0]        alu_result,
  input  logic                   alu_done,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             dbg_state
);

  // Handshake: a command transfers in the cycle cmd_valid && cmd_ready.
  seq_state_e             state_q, state_d;
  logic [Addr:0]          src2_q, src2_d, dst_q, dst_d;
  logic [Addr:0]          b_adbus_q, b_adbus_d;
  logic [Data-1:0]        b_data_in_q, b_data_in_d;
  logic [Data-1:0]        alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
  logic [command_len-1:0] alu_op_q, alu_op_d;
  logic                   b_w_q, b_w_d, alu_start_q, alu_start_d;
  logic                   done_q, done_d, err_q, err_d;
  logic                   cnt_clr, cnt_inc, cnt_term;

  seq_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .terminal (cnt_term)
  );

  always_comb begin
    state_d     = state_q;
    src2_d      = src2_q;
    dst_d       = dst_q;
    b_adbus_d   = b_adbus_q;
    b_data_in_d = b_data_in_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_op_d    = alu_op_q;
    err_d       = err_q;
    b_w_d       = 1'b0;
    alu_start_d = 1'b0;
    done_d      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        src2_d    = cmd_src2;
        dst_d     = cmd_dst;
        alu_op_d  = cmd_op;
        b_adbus_d = cmd_src1;
        err_d     = 1'b0;
        state_d   = RD1;
      end
      RD1: begin
        b_adbus_d = src2_q;
        state_d   = RD2;
      end
      RD2: begin
        alu_op1_d = b_data_out;
        state_d   = CAP2;
      end
      CAP2: begin
        alu_op2_d   = b_data_out;
        alu_start_d = 1'b1;
        cnt_clr     = 1'b1;
        state_d     = EXEC;
      end
      EXEC: begin
        // A done arriving alongside our own start belongs to no operation.
        if (alu_done && !alu_start_q) begin
          b_data_in_d = alu_result;
          b_adbus_d   = dst_q;
          b_w_d       = 1'b1;
          state_d     = WB;
        end else if (cnt_term) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WB: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src2_q      <= '0;
      dst_q       <= '0;
      b_adbus_q   <= '0;
      b_data_in_q <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_op_q    <= '0;
      b_w_q       <= 1'b0;
      alu_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src2_q      <= src2_d;
      dst_q       <= dst_d;
      b_adbus_q   <= b_adbus_d;
      b_data_in_q <= b_data_in_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_op_q    <= alu_op_d;
      b_w_q       <= b_w_d;
      alu_start_q <= alu_start_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Reset in the WB cycle must suppress the write edge itself.
  assign b_w       = b_w_q & ~rst;
  assign b_adbus   = b_adbus_q;
  assign b_data_in = b_data_in_q;
  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_operand_sequencer.sv
// Bench for ram_operand_sequencer: RAM and arithmetic-unit models, vector
// table of commands, and directed timeout / reset / back-to-back sequences.
module tb_ram_operand_sequencer;

  localparam int DW = 256;
  localparam int AM = 5;
  localparam int TO = 15;
  localparam int EW = AM + 1 + DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [0:0]    cmd_op = '0;
  logic [AM:0]   cmd_src1 = '0, cmd_src2 = '0, cmd_dst = '0;
  logic          b_w;
  logic [AM:0]   b_adbus;
  logic [DW-1:0] b_data_in;
  logic [DW-1:0] b_data_out = '0;
  logic          alu_start;
  logic [0:0]    alu_op;
  logic [DW-1:0] alu_op1, alu_op2;
  logic [DW-1:0] alu_result = '0;
  logic          alu_done = 1'b0;
  logic          busy, done, err;
  logic [2:0]    dbg_state;

  logic [DW-1:0] mem [0:63];
  logic          pl_en = 1'b0;
  logic [AM:0]   pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [AM:0]   s1, s2, d;
    logic [0:0]    op;
    int            lat;
    logic [DW-1:0] v1, v2, res;
  } vec_t;
  vec_t vec [5];

  ram_operand_sequencer #(.Data(DW), .Addr(AM), .command_len(1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .b_w(b_w), .b_adbus(b_adbus), .b_data_in(b_data_in), .b_data_out(b_data_out),
    .alu_start(alu_start), .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_done(alu_done), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM port B model: synchronous read with one cycle latency, read-old-data.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (b_w) mem[b_adbus] <= b_data_in;
    b_data_out <= mem[b_adbus];
  end

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AM:0] a, input logic [DW-1:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_b_w"}, EW'(b_w), EW'(0));
    check({tag, "_b_adbus"}, EW'(b_adbus), EW'(0));
    check({tag, "_b_data_in"}, EW'(b_data_in), EW'(0));
    check({tag, "_alu_start"}, EW'(alu_start), EW'(0));
    check({tag, "_alu_op"}, EW'(alu_op), EW'(0));
    check({tag, "_alu_op1"}, EW'(alu_op1), EW'(0));
    check({tag, "_alu_op2"}, EW'(alu_op2), EW'(0));
    check({tag, "_busy"}, EW'(busy), EW'(0));
    check({tag, "_done"}, EW'(done), EW'(0));
    check({tag, "_err"}, EW'(err), EW'(0));
    check({tag, "_cmd_ready"}, EW'(cmd_ready), EW'(1));
    check({tag, "_state"}, EW'(dbg_state), EW'(0));
  endtask

  // Drives one command from an IDLE negedge and acts as the arithmetic unit.
  // lat < 0: unit never answers. spur: extra done in the alu_start cycle.
  task automatic run_cmd(input vec_t v, input bit spur, input bit hold_valid,
                         output int done_cyc, output int n_wr, output bit timed_out);
    int start_c, n_start, ready_busy;
    logic [EW-1:0] got, want;
    cmd_valid = 1'b1; cmd_src1 = v.s1; cmd_src2 = v.s2; cmd_dst = v.d; cmd_op = v.op;
    if (v.lat >= 0) exp_q.push_back({v.d, v.res});
    start_c = -1; n_start = 0; ready_busy = 0; done_cyc = -1; n_wr = 0; timed_out = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      alu_done = 1'b0;
      if (c == 1) begin
        if (!hold_valid) cmd_valid = 1'b0;
        cmd_src1 = 6'($urandom_range(0, 63));
        cmd_src2 = 6'($urandom_range(0, 63));
        cmd_dst  = 6'($urandom_range(0, 63));
        cmd_op   = 1'($urandom_range(0, 1));
        check("busy_after_accept", EW'(busy), EW'(1));
        check("err_cleared_on_accept", EW'(err), EW'(0));
      end
      if (cmd_ready && busy) ready_busy++;
      if (alu_start) begin
        n_start++;
        if (start_c < 0) begin
          start_c = c;
          check("alu_start_cycle", EW'(c), EW'(4));
          check("alu_op1", EW'(alu_op1), EW'(v.v1));
          check("alu_op2", EW'(alu_op2), EW'(v.v2));
          check("alu_op", EW'(alu_op), EW'(v.op));
        end
      end
      if (start_c >= 0 && spur && c == start_c) begin
        alu_done = 1'b1;
        alu_result = DW'(256'hBAD0BAD);
      end
      if (start_c >= 0 && v.lat >= 0 && c == start_c + v.lat) begin
        alu_done = 1'b1;
        alu_result = alu_op[0] ? (alu_op1 + alu_op2) : (alu_op1 * alu_op2);
      end
      if (b_w) begin
        n_wr++;
        got = {b_adbus, b_data_in};
        if (exp_q.size() == 0) check("unexpected_write", got, '0);
        else begin
          want = exp_q.pop_front();
          check("writeback", got, want);
        end
      end
      if (done) begin done_cyc = c; break; end
      if (v.lat < 0 && start_c >= 0 && !busy) begin done_cyc = c; timed_out = 1'b1; break; end
    end
    alu_done = 1'b0;
    if (done_cyc < 0) check("cmd_cycle_budget", EW'(0), EW'(1));
    check("alu_start_count", EW'(n_start), EW'(1));
    check("ready_while_busy", EW'(ready_busy), EW'(0));
  endtask

  // Asserts rst at cycle rst_c of a command whose unit answers after lat.
  task automatic rst_during(input int lat, input int rst_c, input string tag);
    int start_c;
    start_c = -1;
    cmd_valid = 1'b1; cmd_src1 = 6'd3; cmd_src2 = 6'd7; cmd_dst = 6'd40; cmd_op = 1'b1;
    for (int c = 1; c <= rst_c; c++) begin
      @(negedge clk);
      alu_done = 1'b0;
      if (c == 1) cmd_valid = 1'b0;
      if (alu_start && start_c < 0) start_c = c;
      if (start_c >= 0 && c == start_c + lat) begin
        alu_done = 1'b1;
        alu_result = alu_op1 + alu_op2;
      end
    end
    rst = 1'b1;
    alu_done = 1'b0;
    #1;
    check({tag, "_b_w_during_rst"}, EW'(b_w), EW'(0));
    @(negedge clk);
    check_reset_outs(tag);
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_no_ram_write"}, EW'(mem[40]), EW'(8'hAA));
  endtask

  initial begin
    int dc, nw;
    bit to;
    vec_t v;

    vec[0] = '{s1: 6'd3,  s2: 6'd7,  d: 6'd9,  op: 1'b1, lat: 5, v1: 'h11, v2: 'h22, res: 'h33};
    vec[1] = '{s1: 6'd4,  s2: 6'd4,  d: 6'd4,  op: 1'b0, lat: 3, v1: 'h5,  v2: 'h5,  res: 'h19};
    vec[2] = '{s1: 6'd0,  s2: 6'd63, d: 6'd63, op: 1'b1, lat: 1,
               v1: {1'b1, 255'd0}, v2: {1'b1, 255'd1}, res: 'h1};
    vec[3] = '{s1: 6'd10, s2: 6'd20, d: 6'd30, op: 1'b0, lat: 2, v1: 'h1234, v2: 'h10, res: 'h12340};
    vec[4] = '{s1: 6'd5,  s2: 6'd6,  d: 6'd8,  op: 1'b1, lat: 7, v1: 'hFF, v2: 'h1, res: 'h100};

    repeat (3) @(negedge clk);
    check_reset_outs("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("after_reset");

    for (int i = 0; i < 5; i++) begin
      preload(vec[i].s1, vec[i].v1);
      preload(vec[i].s2, vec[i].v2);
    end
    preload(6'd40, 'hAA);

    // Spurious done while idle must not start anything.
    alu_done = 1'b1;
    @(negedge clk);
    alu_done = 1'b0;
    check("idle_spurious_busy", EW'(busy), EW'(0));
    check("idle_spurious_done", EW'(done), EW'(0));
    check("idle_spurious_start", EW'(alu_start), EW'(0));

    for (int i = 0; i < 5; i++) begin
      run_cmd(vec[i], 1'b0, 1'b0, dc, nw, to);
      check($sformatf("vec%0d_latency", i), EW'(dc), EW'(6 + vec[i].lat));
      check($sformatf("vec%0d_writes", i), EW'(nw), EW'(1));
      check($sformatf("vec%0d_err", i), EW'(err), EW'(0));
      check($sformatf("vec%0d_ram", i), EW'(mem[vec[i].d]), EW'(vec[i].res));
      @(negedge clk);
    end

    // Unit never answers: timeout, no writeback, err sticky until next accept.
    v = '{s1: 6'd1, s2: 6'd2, d: 6'd11, op: 1'b1, lat: -1, v1: mem[1], v2: mem[2], res: '0};
    run_cmd(v, 1'b0, 1'b0, dc, nw, to);
    check("timeout_flag", EW'(to), EW'(1));
    check("timeout_cycle", EW'(dc), EW'(4 + TO));
    check("timeout_err", EW'(err), EW'(1));
    check("timeout_ready", EW'(cmd_ready), EW'(1));
    check("timeout_writes", EW'(nw), EW'(0));
    repeat (3) @(negedge clk);
    check("timeout_err_sticky", EW'(err), EW'(1));
    run_cmd(vec[3], 1'b0, 1'b0, dc, nw, to);
    check("after_timeout_err", EW'(err), EW'(0));
    check("after_timeout_latency", EW'(dc), EW'(8));
    @(negedge clk);

    // Done coincident with alu_start is ignored.
    run_cmd(vec[0], 1'b1, 1'b0, dc, nw, to);
    check("spur_start_latency", EW'(dc), EW'(11));
    check("spur_start_ram", EW'(mem[9]), EW'(8'h33));
    @(negedge clk);

    // Back-to-back with cmd_valid held high.
    run_cmd(vec[0], 1'b0, 1'b1, dc, nw, to);
    check("b2b_first_latency", EW'(dc), EW'(11));
    check("b2b_ready_in_done", EW'(cmd_ready), EW'(0));
    @(negedge clk);
    check("b2b_idle_gap", EW'(dbg_state), EW'(0));
    check("b2b_ready_in_idle", EW'(cmd_ready), EW'(1));
    run_cmd(vec[3], 1'b0, 1'b0, dc, nw, to);
    check("b2b_second_latency", EW'(dc), EW'(8));
    @(negedge clk);

    rst_during(5, 6, "rst_exec");
    rst_during(2, 7, "rst_wb");

    check("scoreboard_empty", EW'(exp_q.size()), EW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
